// File: rtl/vend_fsm_param_pkg.sv
// Shared types and constants for the parametrised vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    PAYOUT = 2'd2
  } state_t;

  localparam int unsigned NICKEL   = 1;
  localparam int unsigned DIME     = 2;
  localparam int unsigned QUARTER  = 5;
  localparam int unsigned MAX_PROD = 8;

  // Index of the lowest set bit; lowest product number wins a multi-select.
  function automatic logic [2:0] first_set(input logic [MAX_PROD-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_PROD - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin/select inputs and dispenser/status outputs of the vending controller.
interface vend_fsm_param_if #(
  parameter int unsigned NUM_PROD = 2,
  parameter int unsigned CW       = 5
);
  logic                ni;
  logic                di;
  logic                qu;
  logic [NUM_PROD-1:0] sel;
  logic                cancel;
  logic [NUM_PROD-1:0] give;
  logic                change;
  logic                coin_reject;
  logic [CW-1:0]       credit;
  logic                busy;

  modport master (
    output ni, di, qu, sel, cancel,
    input  give, change, coin_reject, credit, busy
  );

  modport slave (
    input  ni, di, qu, sel, cancel,
    output give, change, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_fsm_param_change_pulser.sv
// Nickel payout timer: CHG_HI cycles high, CHG_LO low, repeating while count is nonzero.
module change_pulser #(
  parameter int unsigned CW     = 5,
  parameter int unsigned CHG_HI = 2,
  parameter int unsigned CHG_LO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  output logic          change,
  output logic          dec,
  output logic          done
);

  localparam int unsigned CMAX  = (CHG_HI > CHG_LO) ? CHG_HI : CHG_LO;
  localparam int unsigned CNT_W = $clog2(CMAX + 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic             hi_end;
  logic             lo_end;

  assign hi_end = (cnt == CNT_W'(CHG_HI - 1));
  assign lo_end = (cnt == CNT_W'(CHG_LO - 1));

  // dec lands on the edge where change falls; count is then already reduced
  assign dec  = running && change && hi_end;
  assign done = running && !change && lo_end && (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      change  <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      change  <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      if (change) begin
        if (hi_end) begin
          change <= 1'b0;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (lo_end) begin
        cnt <= '0;
        if (count == '0) running <= 1'b0;
        else             change  <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vend_fsm_param.sv
// Vending controller: coin credit up to a ceiling, one-hot vend, timed nickel change/refund.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int unsigned NUM_PROD   = 2,
  parameter int unsigned PRICE      = 9,
  parameter int unsigned MAX_CREDIT = 13,
  parameter int unsigned CW         = 5,
  parameter int unsigned CHG_HI     = 2,
  parameter int unsigned CHG_LO     = 1
) (
  input logic              CLK,
  input logic              rst,
  vend_fsm_param_if.slave  bus
);

  state_t              state, state_n;
  logic [CW-1:0]       credit, credit_n;
  logic [NUM_PROD-1:0] give_q, give_n;
  logic                rej_q, rej_n;
  logic                busy_q, busy_n;
  logic [CW-1:0]       coin_val;
  logic [CW-1:0]       sum;
  logic [2:0]          sel_idx;
  logic                coin_any, coin_multi, afford;
  logic                start, dec, done, chg;

  // Coin decode: quarter over dime over nickel; losers count as rejected
  assign coin_any   = bus.ni | bus.di | bus.qu;
  assign coin_multi = (bus.qu & (bus.di | bus.ni)) | (bus.di & bus.ni);
  assign coin_val   = bus.qu ? CW'(QUARTER) : bus.di ? CW'(DIME) : bus.ni ? CW'(NICKEL) : '0;
  assign sum        = credit + coin_val;
  assign sel_idx    = first_set(MAX_PROD'(bus.sel));
  assign afford     = (|bus.sel) && (credit >= CW'(PRICE));

  always_comb begin
    state_n  = state;
    credit_n = credit;
    give_n   = '0;
    rej_n    = 1'b0;
    case (state)
      IDLE: begin
        if (afford) begin
          give_n   = NUM_PROD'(1) << sel_idx;
          credit_n = credit - CW'(PRICE);
          state_n  = VEND;
          rej_n    = coin_any;
        end else begin
          if (coin_any) begin
            if (sum <= CW'(MAX_CREDIT)) begin
              credit_n = sum;
              rej_n    = coin_multi;
            end else begin
              rej_n = 1'b1;
            end
          end
          if (bus.cancel && credit != '0) state_n = PAYOUT;
        end
      end
      VEND: begin
        rej_n   = coin_any;
        state_n = (credit != '0) ? PAYOUT : IDLE;
      end
      PAYOUT: begin
        rej_n = coin_any;
        if (dec)  credit_n = credit - CW'(1);
        if (done) state_n  = IDLE;
      end
      default: begin
        state_n  = IDLE;
        credit_n = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
    start  = (state_n == PAYOUT) && (state != PAYOUT);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state  <= IDLE;
      credit <= '0;
      give_q <= '0;
      rej_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      give_q <= give_n;
      rej_q  <= rej_n;
      busy_q <= busy_n;
    end
  end

  change_pulser #(
    .CW     (CW),
    .CHG_HI (CHG_HI),
    .CHG_LO (CHG_LO)
  ) u_pulser (
    .clk    (CLK),
    .rst    (rst),
    .start  (start),
    .count  (credit),
    .change (chg),
    .dec    (dec),
    .done   (done)
  );

  assign bus.give        = give_q;
  assign bus.change      = chg;
  assign bus.coin_reject = rej_q;
  assign bus.credit      = credit;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: directed scenarios plus random traffic against a timeline model.
module tb_vend_fsm_param;

  localparam int NP = 2;
  localparam int PR = 9;
  localparam int MX = 13;
  localparam int CWD = 5;
  localparam int HI = 2;
  localparam int LO = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vend_fsm_param_if #(.NUM_PROD(NP), .CW(CWD)) bus ();

  vend_fsm_param #(
    .NUM_PROD(NP), .PRICE(PR), .MAX_CREDIT(MX), .CW(CWD), .CHG_HI(HI), .CHG_LO(LO)
  ) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NP-1:0] give;
    logic          change;
    int            credit;
    logic          busy;
  } exp_t;

  exp_t tl[$];   // expected outputs for each upcoming cycle of a vend/payout
  exp_t cur;
  logic cur_rej;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Each nickel: HI cycles high at credit r, then LO cycles low at credit r-1
  task automatic queue_payout(input int k);
    exp_t e;
    for (int j = 0; j < k; j++) begin
      for (int h = 0; h < HI; h++) begin
        e = '{give: '0, change: 1'b1, credit: k - j, busy: 1'b1};
        tl.push_back(e);
      end
      for (int l = 0; l < LO; l++) begin
        e = '{give: '0, change: 1'b0, credit: k - j - 1, busy: 1'b1};
        tl.push_back(e);
      end
    end
    e = '{give: '0, change: 1'b0, credit: 0, busy: 1'b0};
    tl.push_back(e);
  endtask

  task automatic model_step(input bit n, input bit d, input bit q,
                            input logic [NP-1:0] s, input bit c, input bit r);
    int val;
    int idx;
    cur_rej = 1'b0;
    if (r) begin
      tl.delete();
      cur = '{give: '0, change: 1'b0, credit: 0, busy: 1'b0};
      return;
    end
    if (cur.busy) begin
      cur_rej = n | d | q;
      cur = tl.pop_front();
      return;
    end
    val = q ? 5 : d ? 2 : n ? 1 : 0;
    if (s != 0 && cur.credit >= PR) begin
      idx = 0;
      for (int i = NP - 1; i >= 0; i--) if (s[i]) idx = i;
      cur_rej = n | d | q;
      cur = '{give: NP'(1) << idx, change: 1'b0, credit: cur.credit - PR, busy: 1'b1};
      queue_payout(cur.credit);
    end else if (c && cur.credit > 0) begin
      queue_payout(cur.credit);
      cur = tl.pop_front();
    end else begin
      cur.give = '0;
      if (val > 0) begin
        if (cur.credit + val <= MX) begin
          cur.credit = cur.credit + val;
          cur_rej = (int'(n) + int'(d) + int'(q)) > 1;
        end else begin
          cur_rej = 1'b1;
        end
      end
    end
  endtask

  task automatic apply(input bit n, input bit d, input bit q,
                       input logic [NP-1:0] s, input bit c, input bit r);
    bus.ni = n; bus.di = d; bus.qu = q; bus.sel = s; bus.cancel = c; rst = r;
    model_step(n, d, q, s, c, r);
    @(posedge clk); #1;
    check("give", 32'(bus.give), 32'(cur.give));
    check("change", 32'(bus.change), 32'(cur.change));
    check("coin_reject", 32'(bus.coin_reject), 32'(cur_rej));
    check("credit", 32'(bus.credit), 32'(cur.credit));
    check("busy", 32'(bus.busy), 32'(cur.busy));
    bus.ni = 0; bus.di = 0; bus.qu = 0; bus.sel = '0; bus.cancel = 0; rst = 0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) apply(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    bit n, d, q, c, r;
    logic [NP-1:0] s;
    bus.ni = 0; bus.di = 0; bus.qu = 0; bus.sel = '0; bus.cancel = 0; rst = 1;
    cur = '{give: '0, change: 1'b0, credit: 0, busy: 1'b0};
    cur_rej = 1'b0;
    @(posedge clk); #1;
    apply(0, 0, 0, '0, 0, 1);

    // Vend with one nickel of change
    apply(0, 0, 1, '0, 0, 0); apply(0, 0, 1, '0, 0, 0);
    apply(0, 0, 0, 2'b01, 0, 0);
    idle(6);

    // Vend second product, three nickels of change
    apply(0, 0, 1, '0, 0, 0); apply(0, 0, 1, '0, 0, 0); apply(0, 1, 0, '0, 0, 0);
    apply(0, 0, 0, 2'b10, 0, 0);
    idle(12);

    // Ceiling rejection and exact fill
    apply(0, 0, 1, '0, 0, 0); apply(0, 0, 1, '0, 0, 0); apply(0, 0, 1, '0, 0, 0);
    apply(1, 0, 0, '0, 0, 0); apply(1, 0, 0, '0, 0, 0); apply(1, 0, 0, '0, 0, 0);
    apply(1, 0, 0, '0, 0, 0);
    apply(1, 1, 1, '0, 0, 0);
    apply(0, 0, 0, '0, 1, 0);
    idle(42);

    // Unaffordable select then refund
    apply(0, 1, 0, '0, 0, 0); apply(1, 0, 0, '0, 0, 0);
    apply(0, 0, 0, 2'b01, 0, 0);
    apply(0, 0, 0, '0, 1, 0);
    idle(11);

    // Exact price, select with simultaneous coin, coin during VEND
    apply(0, 0, 1, '0, 0, 0); apply(0, 1, 0, '0, 0, 0); apply(0, 1, 0, '0, 0, 0);
    apply(0, 0, 1, 2'b11, 0, 0);
    apply(1, 0, 0, '0, 0, 0);
    idle(3);

    // Reset in the middle of a payout
    apply(0, 0, 1, '0, 0, 0); apply(0, 0, 1, '0, 0, 0); apply(0, 1, 0, '0, 0, 0);
    apply(1, 0, 0, '0, 0, 0);
    apply(0, 0, 0, 2'b01, 0, 0);
    idle(4);
    apply(0, 0, 0, '0, 0, 1);
    apply(1, 0, 0, '0, 0, 0);
    idle(2);

    // Random traffic; cancel is never paired with a coin
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 15) == 0);
      n = !c && ($urandom_range(0, 3) == 0);
      d = !c && ($urandom_range(0, 3) == 0);
      q = !c && ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 5) == 0) ? NP'($urandom_range(1, 3)) : '0;
      apply(n, d, q, s, c, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
Parametrised successor to the team's two-product vending controller. It accumulates nickel, dime and quarter credit up to a configurable ceiling and rejects coins that would overflow it. It vends one of NUM_PROD products at a configurable price, then pays out the remainder as timed nickel pulses. It also supports cancel/refund and exposes the live credit. It sits between the coin-sense/button debouncers and the dispenser drivers.

Parameters:
NUM_PROD, 2, number of selectable products (1..8)
PRICE, 9, product price in nickels (9 = 45 cents); 1..MAX_CREDIT
MAX_CREDIT, 13, credit ceiling in nickels (13 = 65 cents)
CW, 5, credit width; must satisfy 2**CW > MAX_CREDIT+5
CHG_HI, 2, cycles the change output is held high per nickel (>=1)
CHG_LO, 1, cycles the change output is held low between nickels (>=1)

Ports:
CLK  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
ni  in  1  nickel inserted, 1-cycle pulse
di  in  1  dime inserted, 1-cycle pulse
qu  in  1  quarter inserted, 1-cycle pulse
sel  in  NUM_PROD  product select request, level or pulse
cancel  in  1  refund request
give  out  NUM_PROD  vend strobe, one-hot, 1 cycle
change  out  1  nickel payout pulse train
coin_reject  out  1  coin returned, 1 cycle
credit  out  CW  current credit in nickels (registered)
busy  out  1  high in VEND/PAYOUT

Behaviour:
- Reset: state=IDLE, credit=0, give=0, change=0, coin_reject=0, busy=0. Any pending payout is discarded. Reset has priority over every input.
- States: IDLE, VEND, PAYOUT. All outputs are registered.
- Coin decode: qu>di>ni priority, values 5/2/1 nickels. At most one coin is accepted per cycle. Lower-priority simultaneous coins are rejected, with a single coin_reject pulse.
- IDLE, coin present:
  - credit+value <= MAX_CREDIT: credit += value next cycle.
  - Otherwise: credit unchanged, coin_reject=1 for 1 cycle.
- IDLE, sel!=0 and credit >= PRICE: lowest set bit i wins.
  - Next cycle: give[i]=1, credit -= PRICE, state=VEND.
  - A coin arriving the same cycle is rejected (sel has priority).
- IDLE, sel!=0 and credit < PRICE: sel is ignored. No output, no state change. The coin path still operates.
- IDLE, cancel and no affordable sel: if credit>0, state=PAYOUT (refund); otherwise ignored. If cancel and an affordable sel arrive together, sel wins and cancel is dropped.
- VEND (1 cycle): give returns to 0. Next state is PAYOUT if credit>0, else IDLE.
- PAYOUT:
  - change is high for CHG_HI cycles, then low for CHG_LO cycles.
  - credit decrements by 1 on the cycle change falls.
  - The cycle repeats until credit=0, then state=IDLE.
  - Refund credit k gives exactly k pulses.
- VEND and PAYOUT: every coin produces coin_reject; sel and cancel are ignored; busy=1.
- Back-to-back: the cycle PAYOUT finishes, IDLE accepts a new coin. A vend followed by change takes 1 + k*(CHG_HI+CHG_LO) cycles after give.
- Credit never exceeds MAX_CREDIT and never goes negative. Any other state value returns to IDLE with credit cleared.
- No # delays; synthesizable only.

Decomposition:
- Package vend_pkg: state enum/localparams (IDLE, VEND, PAYOUT); coin value constants NICKEL=1, DIME=2, QUARTER=5; a priority-encode function for sel.
- One sub-module, change_pulser:
  - Interface: start, count[CW-1:0] in; change, dec, done out.
  - Owns the CHG_HI/CHG_LO cycle counter.
  - The parent keeps credit and decrements it on dec.

Test Plan:
1. Defaults; qu,qu then sel=2'b01 → credit 5→10; give=01 for 1 cycle; credit 1; one change pulse 2 cycles high; credit 0; IDLE 4 cycles after give.
2. qu,qu,di then sel=2'b10 → credit 12; give=10; 3 change pulses (2 high/1 low); coin_reject never asserted.
3. qu,qu,qu → third coin rejected, coin_reject 1 cycle, credit stays 10; then ni,ni,ni → credit 13; ni → rejected.
4. di,ni (credit 3), sel=2'b01 → no give, credit 3; cancel → 3 change pulses, credit 0, busy drops.
5. credit 9; sel=2'b11 with qu in the same cycle → give=01, coin_reject=1, credit 0, no change pulses; a ni during VEND is rejected.
6. credit 13, sel → PAYOUT with 4 nickels pending; assert rst after 1 pulse → change=0, credit=0, IDLE; the next ni gives credit 1.
